// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS subset core:
// opcode/funct values, FSM state codes, ALU control codes and a legality check.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE:
            ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND)
              || (fn == FN_OR)  || (fn == FN_SLT);
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J:
            ok = 1'b1;
         default:
            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: two operand read ports, one debug read port, one write port.
// Ports: ra/rb/dbg_ra read indices -> rd_a/rd_b/dbg_rd; we/wa/wd write; rst clears all.
module mips_regfile #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] ra,
   input  logic [REG_ADDR_W-1:0] rb,
   input  logic [REG_ADDR_W-1:0] dbg_ra,
   output logic [DATA_W-1:0]     rd_a,
   output logic [DATA_W-1:0]     rd_b,
   output logic [DATA_W-1:0]     dbg_rd,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0]     wd
);

   localparam int NREG = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // r0 reads as zero on every port regardless of storage
   assign rd_a   = (ra == '0)     ? '0 : regs[ra];
   assign rd_b   = (rb == '0)     ? '0 : regs[rb];
   assign dbg_rd = (dbg_ra == '0) ? '0 : regs[dbg_ra];

endmodule

// File: rtl/mips_multiciclo_core.sv
// Multi-cycle MIPS subset core: PC, IR, register file, ALU and control FSM.
// Ports: imem_* instruction ROM, dmem_* sync-read data RAM, dbg_* register peek, status outputs.
module mips_multiciclo_core
   import mips_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int PC_W       = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic [PC_W-1:0]       imem_addr,
   input  logic [31:0]           imem_rdata,
   output logic [DATA_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   output logic                  dmem_we,
   input  logic [DATA_W-1:0]     dmem_rdata,
   input  logic [REG_ADDR_W-1:0] dbg_ra,
   output logic [DATA_W-1:0]     dbg_rd,
   output logic [PC_W-1:0]       pc,
   output logic [2:0]            state,
   output logic                  retired,
   output logic [CNT_W-1:0]      instr_cnt,
   output logic                  halted
);

   state_t            state_q;
   logic [PC_W-1:0]   pc_q;
   logic [31:0]       ir;
   logic [DATA_W-1:0] a_q, b_q, alu_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [5:0]            op, fn;
   logic [REG_ADDR_W-1:0] rs_ix, rt_ix, rd_ix;
   logic [DATA_W-1:0]     rs_val, rt_val, alu_b, alu_res;
   logic                  retire_c, rf_we;
   logic [REG_ADDR_W-1:0] rf_wa;
   logic [DATA_W-1:0]     rf_wd;
   logic                  unused_ir;

   assign op    = ir[31:26];
   assign fn    = ir[5:0];
   assign rs_ix = ir[21 +: REG_ADDR_W];
   assign rt_ix = ir[16 +: REG_ADDR_W];
   assign rd_ix = ir[11 +: REG_ADDR_W];
   assign unused_ir = ^ir;

   function automatic alu_op_t alu_ctrl(logic [5:0] o, logic [5:0] f);
      alu_op_t c;
      c = ALU_ADD;
      if (o == OP_RTYPE) begin
         case (f)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
         endcase
      end
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] alu(alu_op_t c, logic [DATA_W-1:0] x, logic [DATA_W-1:0] y);
      logic [DATA_W-1:0] r;
      case (c)
         ALU_SUB: r = x - y;
         ALU_AND: r = x & y;
         ALU_OR:  r = x | y;
         ALU_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(x) < $signed(y))};
         default: r = x + y;
      endcase
      return r;
   endfunction

   // immediate forms (addi/lw/sw) add the truncated imm to rs
   assign alu_b   = (op == OP_RTYPE) ? b_q : ir[DATA_W-1:0];
   assign alu_res = alu(alu_ctrl(op, fn), a_q, alu_b);

   mips_regfile #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .ra     (rs_ix),
      .rb     (rt_ix),
      .dbg_ra (dbg_ra),
      .rd_a   (rs_val),
      .rd_b   (rt_val),
      .dbg_rd (dbg_rd),
      .we     (rf_we),
      .wa     (rf_wa),
      .wd     (rf_wd)
   );

   // strobes are gated by en so a frozen core never writes or retires
   assign retire_c = en && (((state_q == ST_EXEC) && ((op == OP_BEQ) || (op == OP_J)))
                         || ((state_q == ST_MEM) && (op == OP_SW))
                         || (state_q == ST_WB));
   assign dmem_we  = en && (state_q == ST_MEM) && (op == OP_SW);
   assign rf_we    = en && (state_q == ST_WB);
   assign rf_wa    = (op == OP_RTYPE) ? rd_ix : rt_ix;
   assign rf_wd    = (op == OP_LW) ? dmem_rdata : alu_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         cnt_q   <= '0;
      end else if (en) begin
         unique case (state_q)
            ST_FETCH: begin
               ir      <= imem_rdata;
               pc_q    <= pc_q + PC_W'(1);
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               a_q     <= rs_val;
               b_q     <= rt_val;
               state_q <= is_legal(op, fn) ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
               alu_q <= alu_res;
               if (op == OP_BEQ) begin
                  // PC already points past the branch
                  if (a_q == b_q) pc_q <= pc_q + ir[PC_W-1:0];
                  state_q <= ST_FETCH;
               end else if (op == OP_J) begin
                  pc_q    <= ir[PC_W-1:0];
                  state_q <= ST_FETCH;
               end else if ((op == OP_LW) || (op == OP_SW)) begin
                  state_q <= ST_MEM;
               end else begin
                  state_q <= ST_WB;
               end
            end
            ST_MEM:  state_q <= (op == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:   state_q <= ST_FETCH;
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_FETCH;
         endcase
         if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign state      = state_q;
   assign dmem_addr  = alu_q;
   assign dmem_wdata = b_q;
   assign retired    = retire_c;
   assign instr_cnt  = cnt_q;
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_mips_multiciclo_core.sv
// Self-checking bench for mips_multiciclo_core: directed vector table,
// multi-cycle corner sequences and random programs against an ISA-level model.
module tb_mips_multiciclo_core;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_we;
   logic [2:0]  dbg_ra;
   logic [7:0]  dbg_rd, pc;
   logic [2:0]  state;
   logic        retired;
   logic [15:0] instr_cnt;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;

   mips_multiciclo_core dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_rdata (dmem_rdata),
      .dbg_ra     (dbg_ra),
      .dbg_rd     (dbg_rd),
      .pc         (pc),
      .state      (state),
      .retired    (retired),
      .instr_cnt  (instr_cnt),
      .halted     (halted)
   );

   always #10 clk = ~clk;

   logic [31:0] rom [256];
   logic [7:0]  ram [256] = '{default: 8'h00};

   assign imem_rdata = rom[imem_addr];

   always @(posedge clk) begin
      if (dmem_we) ram[dmem_addr] <= dmem_wdata;
      dmem_rdata <= ram[dmem_addr];
   end

   int         we_count = 0;
   logic [7:0] we_addr, we_data;
   always @(negedge clk) begin
      if (dmem_we) begin
         we_count <= we_count + 1;
         we_addr  <= dmem_addr;
         we_data  <= dmem_wdata;
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en  = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic run_instr(output int cyc, output bit done);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 12) begin
         cyc++;
         done = retired;
         tick();
      end
   endtask

   task automatic read_reg(input logic [2:0] ix, output logic [7:0] v);
      dbg_ra = ix;
      #1;
      v = dbg_rd;
   endtask

   function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rt, logic [4:0] rs, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // ---------------- ISA-level reference model ----------------
   logic [7:0] mpc;
   logic [7:0] mreg [8];
   logic [7:0] mmem [256];

   task automatic model_step(output int lat, output bit is_sw,
                             output logic [7:0] sa, output logic [7:0] sd);
      logic [31:0] w;
      logic [7:0]  a, b, im, r, ea;
      logic [2:0]  rs, rt, rd;
      w  = rom[mpc];
      mpc = mpc + 8'd1;
      rs = w[23:21];
      rt = w[18:16];
      rd = w[13:11];
      a  = mreg[rs];
      b  = mreg[rt];
      im = w[7:0];
      ea = a + im;
      is_sw = 1'b0;
      sa = 8'h00;
      sd = 8'h00;
      lat = 0;
      r = 8'h00;
      case (w[31:26])
         6'h00: begin
            case (w[5:0])
               6'h20: r = a + b;
               6'h22: r = a - b;
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h2A: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
               default: r = 8'h00;
            endcase
            if (rd != 3'd0) mreg[rd] = r;
            lat = 4;
         end
         6'h08: begin
            if (rt != 3'd0) mreg[rt] = ea;
            lat = 4;
         end
         6'h23: begin
            if (rt != 3'd0) mreg[rt] = mmem[ea];
            lat = 5;
         end
         6'h2B: begin
            mmem[ea] = b;
            is_sw = 1'b1;
            sa = ea;
            sd = b;
            lat = 4;
         end
         6'h04: begin
            if (a == b) mpc = mpc + im;
            lat = 3;
         end
         6'h02: begin
            mpc = w[7:0];
            lat = 3;
         end
         default: lat = 0;
      endcase
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fns [5];
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      int k;
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      k   = int'($urandom_range(0, 9));
      case (k)
         5:       return enc_i(6'h08, rt, rs, imm);
         6:       return enc_i(6'h23, rt, rs, imm);
         7:       return enc_i(6'h2B, rt, rs, imm);
         8:       return enc_i(6'h04, rt, rs, imm);
         9:       return {6'h02, 26'($urandom)};
         default: return enc_r(fns[k], rd, rs, rt);
      endcase
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [7:0]  addr;
      logic [31:0] instr;
      int          lat;
      logic [2:0]  ridx;
      logic [7:0]  rval;
      logic [7:0]  pc_after;
      bit          is_sw;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int         cyc, wc, lat;
      bit         done, sw;
      logic [7:0] v, sa, sd;
      int         rets;

      rst = 1'b0;
      en = 1'b1;
      dbg_ra = 3'd0;
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;

      vecs[0]  = '{8'd0,  enc_i(6'h08, 5'd1, 5'd0, 16'd5),       4, 3'd1, 8'd5,  8'd1,  1'b0};
      vecs[1]  = '{8'd1,  enc_i(6'h08, 5'd2, 5'd0, 16'd3),       4, 3'd2, 8'd3,  8'd2,  1'b0};
      vecs[2]  = '{8'd2,  enc_r(6'h20, 5'd3, 5'd1, 5'd2),        4, 3'd3, 8'd8,  8'd3,  1'b0};
      vecs[3]  = '{8'd3,  enc_r(6'h22, 5'd4, 5'd2, 5'd1),        4, 3'd4, 8'hFE, 8'd4,  1'b0};
      vecs[4]  = '{8'd4,  enc_r(6'h2A, 5'd5, 5'd4, 5'd1),        4, 3'd5, 8'd1,  8'd5,  1'b0};
      vecs[5]  = '{8'd5,  enc_r(6'h20, 5'd0, 5'd1, 5'd1),        4, 3'd0, 8'd0,  8'd6,  1'b0};
      vecs[6]  = '{8'd6,  enc_i(6'h2B, 5'd3, 5'd0, 16'h0010),    4, 3'd3, 8'd8,  8'd7,  1'b1};
      vecs[7]  = '{8'd7,  enc_i(6'h23, 5'd6, 5'd0, 16'h0010),    5, 3'd6, 8'd8,  8'd8,  1'b0};
      vecs[8]  = '{8'd8,  {6'h02, 26'd10},                       3, 3'd6, 8'd8,  8'd10, 1'b0};
      vecs[9]  = '{8'd10, enc_i(6'h04, 5'd2, 5'd1, 16'd5),       3, 3'd1, 8'd5,  8'd11, 1'b0};
      vecs[10] = '{8'd11, enc_r(6'h24, 5'd7, 5'd1, 5'd2),        4, 3'd7, 8'd1,  8'd12, 1'b0};
      vecs[11] = '{8'd12, enc_r(6'h25, 5'd7, 5'd1, 5'd2),        4, 3'd7, 8'd7,  8'd13, 1'b0};
      vecs[12] = '{8'd13, enc_i(6'h08, 5'd7, 5'd7, 16'hFFFF),    4, 3'd7, 8'd6,  8'd14, 1'b0};
      vecs[13] = '{8'd14, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),    3, 3'd1, 8'd5,  8'd14, 1'b0};
      vecs[14] = '{8'd14, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),    3, 3'd1, 8'd5,  8'd14, 1'b0};
      vecs[15] = '{8'd14, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),    3, 3'd1, 8'd5,  8'd14, 1'b0};
      foreach (vecs[i]) rom[vecs[i].addr] = vecs[i].instr;

      do_reset();
      check("rst_pc", pc, 0);
      check("rst_state", state, 0);
      check("rst_cnt", instr_cnt, 0);
      check("rst_halted", halted, 0);
      check("rst_retired", retired, 0);
      check("rst_we", dmem_we, 0);
      for (int r = 0; r < 8; r++) begin
         read_reg(3'(r), v);
         check("rst_reg", v, 0);
      end

      foreach (vecs[i]) begin
         wc = we_count;
         run_instr(cyc, done);
         check("vec_done", done, 1);
         check("vec_lat", cyc, vecs[i].lat);
         check("vec_pc", pc, vecs[i].pc_after);
         check("vec_cnt", instr_cnt, i + 1);
         check("vec_we_count", we_count - wc, vecs[i].is_sw ? 1 : 0);
         if (vecs[i].is_sw) begin
            check("sw_addr", we_addr, 8'h10);
            check("sw_data", we_data, 8'd8);
         end
         read_reg(vecs[i].ridx, v);
         check("vec_reg", v, vecs[i].rval);
      end

      // PC wrap from 0xFF to 0x00
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;
      rom[0]    = {6'h02, 26'hFF};
      rom[8'hFF] = enc_i(6'h08, 5'd1, 5'd0, 16'd9);
      do_reset();
      run_instr(cyc, done);
      check("wrap_j_lat", cyc, 3);
      check("wrap_j_pc", pc, 8'hFF);
      run_instr(cyc, done);
      check("wrap_lat", cyc, 4);
      check("wrap_pc", pc, 8'h00);
      read_reg(3'd1, v);
      check("wrap_r1", v, 8'd9);

      // illegal opcode halts with PC frozen past it
      rom[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
      rom[1] = enc_i(6'h08, 5'd2, 5'd0, 16'd2);
      rom[2] = {6'h3F, 26'h0};
      rom[3] = enc_i(6'h08, 5'd3, 5'd0, 16'd3);
      do_reset();
      run_instr(cyc, done);
      run_instr(cyc, done);
      rets = 0;
      repeat (15) begin
         if (retired) rets++;
         tick();
      end
      check("halt_retired", rets, 0);
      check("halt_flag", halted, 1);
      check("halt_state", state, 5);
      check("halt_pc", pc, 3);
      check("halt_cnt", instr_cnt, 2);
      read_reg(3'd3, v);
      check("halt_r3", v, 0);

      // unknown funct under op 0 is illegal too
      rom[0] = enc_r(6'h3F, 5'd1, 5'd0, 5'd0);
      do_reset();
      check("halt2_clear", halted, 0);
      repeat (3) tick();
      check("halt2_state", state, 5);
      check("halt2_pc", pc, 1);

      // en low during MEM of sw, then reset mid-lw
      rom[0] = enc_i(6'h08, 5'd1, 5'd0, 16'h55);
      rom[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'h20);
      rom[2] = enc_i(6'h23, 5'd2, 5'd0, 16'h20);
      do_reset();
      run_instr(cyc, done);
      repeat (3) tick();
      check("fz_state_mem", state, 3);
      en = 1'b0;
      #1;
      wc = we_count;
      check("fz_we_off", dmem_we, 0);
      check("fz_ret_off", retired, 0);
      repeat (4) tick();
      check("fz_hold_state", state, 3);
      check("fz_hold_pc", pc, 2);
      check("fz_hold_cnt", instr_cnt, 1);
      check("fz_no_we", we_count, wc);
      en = 1'b1;
      #1;
      check("fz_we_on", dmem_we, 1);
      check("fz_ret_on", retired, 1);
      check("fz_addr", dmem_addr, 8'h20);
      check("fz_wdata", dmem_wdata, 8'h55);
      tick();
      check("fz_we_once", we_count, wc + 1);
      check("fz_ram", ram[8'h20], 8'h55);
      check("fz_cnt", instr_cnt, 2);
      repeat (4) tick();
      check("rl_state_wb", state, 4);
      #3;
      rst = 1'b1;
      #1;
      check("rl_pc", pc, 0);
      check("rl_state", state, 0);
      check("rl_cnt", instr_cnt, 0);
      check("rl_ret", retired, 0);
      read_reg(3'd1, v);
      check("rl_r1", v, 0);
      tick();
      rst = 1'b0;
      read_reg(3'd2, v);
      check("rl_r2", v, 0);
      tick();
      check("rl_fetch_pc", pc, 1);

      // random programs against the ISA model
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      for (int i = 0; i < 256; i++) mmem[i] = ram[i];
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      mpc = 8'h00;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         model_step(lat, sw, sa, sd);
         wc = we_count;
         run_instr(cyc, done);
         check("rnd_done", done, 1);
         check("rnd_lat", cyc, lat);
         check("rnd_pc", pc, mpc);
         check("rnd_we_count", we_count - wc, sw ? 1 : 0);
         if (sw) begin
            check("rnd_sw_addr", we_addr, sa);
            check("rnd_sw_data", we_data, sd);
         end
         for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), v);
            check("rnd_reg", v, mreg[r]);
         end
      end
      check("rnd_cnt", instr_cnt, 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
